gps_signal_gen: RTL and testbench
=================================

# gps_signal_gen

Synthesizable emulator of the PmodGPS status pins. Drives `onepps_o` and `threedf_o` with the waveforms a real receiver produces while searching, acquiring and holding a 3D fix. Sits in place of the PmodGPS in hardware self-test builds and feeds the fix-detection FSM (`onepps_i`/`threedf_i`), so the speedo path can be exercised without sky view.

## Interface
- `period_cycles_p`, 12_000_000: clocks per 1 s period (12 MHz iCEBreaker); must be ≥ 4.
- `pps_width_p`, 1_200_000: 1PPS high time in clocks (100 ms); must satisfy 1 ≤ `pps_width_p` < `period_cycles_p`.
- `acquire_periods_p`, 3: number of full periods spent in ACQUIRE before FIX; must be ≥ 1.

- `clk_i`  in  1  single clock; all logic on posedge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `en_i`  in  1  emulator enable; 0 forces IDLE.
- `fix_req_i`  in  1  scenario control: 1 = satellites visible (go toward fix), 0 = no fix.
- `onepps_o`  out  1  emulated 1PPS pulse.
- `threedf_o`  out  1  emulated 3DF pin: blinks while not fixed, low when fixed.
- `locked_o`  out  1  high while the emulator is in FIX.

## Operation
- Period counter `cnt_r`, width $clog2(`period_cycles_p`), counts 0 … `period_cycles_p`-1, then wraps to 0. `tick` = (`cnt_r` == `period_cycles_p`-1). The counter runs in every state except IDLE, where it is held at 0.
- Acquire counter `acq_r`, width $clog2(`acquire_periods_p`+1), is cleared on entry to ACQUIRE.
- IDLE: `en_i`=1 → SEARCH next cycle, with `cnt_r`=0.
- SEARCH: at `tick`, `fix_req_i`=1 → ACQUIRE and `acq_r`←0; otherwise remain in SEARCH.
- ACQUIRE: at `tick`:
  - `fix_req_i`=0 → SEARCH.
  - `acq_r`==`acquire_periods_p`-1 → FIX.
  - Otherwise `acq_r`++.
  - ACQUIRE therefore lasts exactly `acquire_periods_p` periods.
- FIX: at `tick`, `fix_req_i`=0 → SEARCH; otherwise remain in FIX.
- `fix_req_i` is only sampled at `tick`. Changes between ticks have no effect.
- `en_i`=0 in any state → IDLE next cycle with `cnt_r`←0 and `acq_r`←0. `en_i` has priority over the `tick` transitions.
- Output decode, computed from `state_r`/`cnt_r`:
  - `threedf_o` = (state ∈ {SEARCH, ACQUIRE}) & (`cnt_r` < `period_cycles_p`/2), using integer division.
  - `onepps_o` = (state == FIX) & (`cnt_r` < `pps_width_p`).
  - `locked_o` = (state == FIX).
  - In IDLE all outputs are 0.

## Timing
- Reset: `state_r`=IDLE, `cnt_r`=0, `acq_r`=0. `onepps_o`, `threedf_o` and `locked_o` are all 0 in the cycle following reset assertion and stay 0 until after release.
- Outputs are registered and lag `state_r`/`cnt_r` by one cycle; they are glitch-free.
- From `en_i` rising with `fix_req_i` held at 1, the first `onepps_o` rising edge occurs `period_cycles_p`×(1+`acquire_periods_p`) + 2 cycles later:
  - 1 cycle IDLE→SEARCH.
  - One SEARCH period.
  - `acquire_periods_p` ACQUIRE periods.
  - 1 cycle output register.
- Each `onepps_o` pulse is exactly `pps_width_p` cycles; rising edges are exactly `period_cycles_p` apart. `threedf_o` in blink states is high for ⌊P/2⌋ cycles and low for P-⌊P/2⌋ cycles.
- FIX→SEARCH at `tick`: `threedf_o` rises in the first cycle of the new period; no partial 1PPS is emitted.
- Reset mid-operation: IDLE on the next cycle, with the output-register behaviour above. No pulse is stretched.

## Structure
- Package `gps_signal_gen_pkg`: state enum `gen_state_e` {IDLE, SEARCH, ACQUIRE, FIX}, 2-bit.
- Sub-module `period_ticker`:
  - Parameter `period_cycles_p`; inputs `clk_i`, `rst_i`, `clr_i`; outputs `cnt_o` and `tick_o`.
  - Wrapping counter, cleared by reset or `clr_i`.
  - Instantiated once.
- Top level holds the FSM, `acq_r` and the output registers.

## Test plan
Scenarios use `period_cycles_p`=10, `pps_width_p`=2, `acquire_periods_p`=2.
- Reset 10 cycles, `en_i`=0 → all outputs 0 for 100 cycles.
- `en_i`=1, `fix_req_i`=0 → `threedf_o` alternates 5 high/5 low; `onepps_o`=0 and `locked_o`=0 throughout.
- `en_i`=1, `fix_req_i`=1 from the start → first `onepps_o` rise 32 cycles after `en_i`; `onepps_o` then repeats 2 high/8 low; `locked_o`=1 and `threedf_o`=0 while `onepps_o` is pulsing.
- In FIX, drop `fix_req_i` mid-period → the current 1PPS period completes, then `threedf_o` resumes blinking at the next period start, with no extra pulse.
- In ACQUIRE, drop `fix_req_i` before the 2nd `tick` → return to SEARCH; re-raising it requires a full 2 ACQUIRE periods again.
- Assert `rst_i` (or clear `en_i`) during a `onepps_o` high → all outputs 0 on the following cycle; `cnt_r`=0.

Source files
------------

// File: rtl/gps_signal_gen_pkg.sv
// Shared types and helpers for the PmodGPS status-pin emulator.
package gps_signal_gen_pkg;

    // Emulated receiver phases: powered off, searching sky, acquiring, holding a 3D fix.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        ACQUIRE = 2'd2,
        FIX     = 2'd3
    } gen_state_e;

endpackage

// File: rtl/gps_signal_gen_if.sv
// Control and status bundle between a scenario driver and the GPS pin emulator.
// Control is level-based, not a handshake: en_i and fix_req_i are held levels
// that the emulator samples every cycle (fix_req_i only matters at a period tick).
// The status pins are registered levels with no acknowledge. state_o/cnt_o
// expose the FSM state and period counter for observation.
interface gps_signal_gen_if
    import gps_signal_gen_pkg::*;
#(
    parameter int period_cycles_p = 12_000_000
);
    logic                               en_i;
    logic                               fix_req_i;
    logic                               onepps_o;
    logic                               threedf_o;
    logic                               locked_o;
    gen_state_e                         state_o;
    logic [$clog2(period_cycles_p)-1:0] cnt_o;

    // Scenario driver side.
    modport master (
        output en_i, fix_req_i,
        input  onepps_o, threedf_o, locked_o, state_o, cnt_o
    );

    // Emulator side.
    modport slave (
        input  en_i, fix_req_i,
        output onepps_o, threedf_o, locked_o, state_o, cnt_o
    );
endinterface

// File: rtl/gps_signal_gen_period_ticker.sv
// Free-running period counter: counts 0 .. period_cycles_p-1 and wraps,
// flagging the last count of each period as the tick.
module period_ticker #(
    parameter int period_cycles_p = 12_000_000
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clr_i,
    output logic [$clog2(period_cycles_p)-1:0] cnt_o,
    output logic                               tick_o
);
    localparam int CNT_W = $clog2(period_cycles_p);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(period_cycles_p - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == LAST_C);

    // Advance the counter, wrapping at the end of the period; clear holds it at 0.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o  = r_cnt;
    assign tick_o = w_tick;
endmodule

// File: rtl/gps_signal_gen.sv
// PmodGPS status-pin emulator: produces 1PPS and 3DF waveforms for the
// search / acquire / fix sequence so the fix detector can run without sky view.
module gps_signal_gen
    import gps_signal_gen_pkg::*;
#(
    parameter int period_cycles_p   = 12_000_000,
    parameter int pps_width_p       = 1_200_000,
    parameter int acquire_periods_p = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    gps_signal_gen_if.slave  bus
);
    localparam int CNT_W = $clog2(period_cycles_p);
    localparam int ACQ_W = $clog2(acquire_periods_p + 1);
    localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(period_cycles_p / 2);
    localparam logic [CNT_W-1:0] PPS_C    = CNT_W'(pps_width_p);
    localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(acquire_periods_p - 1);

    gen_state_e       r_state;
    gen_state_e       w_state_nxt;
    logic [ACQ_W-1:0] r_acq;
    logic [ACQ_W-1:0] w_acq_nxt;
    logic [CNT_W-1:0] w_cnt;
    logic             w_tick;
    logic             w_clr;
    logic             r_onepps;
    logic             r_threedf;
    logic             r_locked;

    // Counter is parked at 0 in IDLE and forced there as soon as the emulator is disabled,
    // so the first SEARCH cycle always starts a fresh period.
    assign w_clr = ~bus.en_i | (r_state == IDLE);

    period_ticker #(
        .period_cycles_p (period_cycles_p)
    ) u_ticker (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_clr),
        .cnt_o  (w_cnt),
        .tick_o (w_tick)
    );

    // State and acquire-period registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_acq   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acq   <= w_acq_nxt;
        end
    end

    // Next-state logic: disable wins over everything; fix_req_i only matters at a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_acq_nxt   = r_acq;
        if (!bus.en_i) begin
            w_state_nxt = IDLE;
            w_acq_nxt   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt = SEARCH;
                end
                SEARCH: begin
                    if (w_tick && bus.fix_req_i) begin
                        w_state_nxt = ACQUIRE;
                        w_acq_nxt   = '0;
                    end
                end
                ACQUIRE: begin
                    if (w_tick) begin
                        if (!bus.fix_req_i) begin
                            w_state_nxt = SEARCH;
                        end else if (r_acq == ACQ_LAST) begin
                            w_state_nxt = FIX;
                        end else begin
                            w_acq_nxt = r_acq + 1'b1;
                        end
                    end
                end
                FIX: begin
                    if (w_tick && !bus.fix_req_i) begin
                        w_state_nxt = SEARCH;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Registered pin decode; reset or disable blanks the pins on the very next cycle
    // so a pulse in flight is cut rather than stretched.
    always_ff @(posedge clk_i) begin
        if (rst_i || !bus.en_i) begin
            r_onepps  <= 1'b0;
            r_threedf <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_onepps  <= (r_state == FIX) && (w_cnt < PPS_C);
            r_threedf <= ((r_state == SEARCH) || (r_state == ACQUIRE)) && (w_cnt < HALF_C);
            r_locked  <= (r_state == FIX);
        end
    end

    assign bus.onepps_o  = r_onepps;
    assign bus.threedf_o = r_threedf;
    assign bus.locked_o  = r_locked;
    assign bus.state_o   = r_state;
    assign bus.cnt_o     = w_cnt;
endmodule

// File: tb/tb_gps_signal_gen.sv
// Bench for the GPS pin emulator with a small period so whole scenarios fit in a few hundred cycles.
module tb_gps_signal_gen;
    import gps_signal_gen_pkg::*;

    localparam int P     = 10;
    localparam int PPS_W = 2;
    localparam int ACQ_N = 2;
    localparam int CW    = $clog2(P);

    logic clk;
    logic rst;

    gps_signal_gen_if #(.period_cycles_p(P)) bus ();

    gps_signal_gen #(
        .period_cycles_p   (P),
        .pps_width_p       (PPS_W),
        .acquire_periods_p (ACQ_N)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: receiver phase, position inside the current second,
    // and how many acquire seconds are still owed before the fix is granted.
    gen_state_e m_mode;
    int         m_pos;
    int         m_acq_left;
    logic [2:0] exp_q[$];   // {onepps, threedf, locked} expected after each edge

    // Advance one clock: predict the pins for the cycle after this edge from the
    // phase we were in, then move the model along, then settle 1 time unit past the edge.
    task automatic step();
        logic [2:0] e;
        bit         last;
        @(posedge clk);
        if (rst || !bus.en_i) begin
            e = 3'b000;
        end else begin
            e[2] = (m_mode == FIX) && (m_pos < PPS_W);
            e[1] = ((m_mode == SEARCH) || (m_mode == ACQUIRE)) && (m_pos < P / 2);
            e[0] = (m_mode == FIX);
        end
        exp_q.push_back(e);
        if (rst || !bus.en_i) begin
            m_mode     = IDLE;
            m_pos      = 0;
            m_acq_left = 0;
        end else if (m_mode == IDLE) begin
            m_mode = SEARCH;
            m_pos  = 0;
        end else begin
            last  = (m_pos == P - 1);
            m_pos = last ? 0 : m_pos + 1;
            if (last) begin
                if (m_mode == SEARCH && bus.fix_req_i) begin
                    m_mode     = ACQUIRE;
                    m_acq_left = ACQ_N;
                end else if (m_mode == ACQUIRE) begin
                    if (!bus.fix_req_i) begin
                        m_mode = SEARCH;
                    end else begin
                        m_acq_left = m_acq_left - 1;
                        if (m_acq_left == 0) m_mode = FIX;
                    end
                end else if (m_mode == FIX && !bus.fix_req_i) begin
                    m_mode = SEARCH;
                end
            end
        end
        #1;
    endtask

    // Bring DUT and model back to a clean IDLE.
    task automatic go_idle();
        rst           = 1'b1;
        bus.en_i      = 1'b0;
        bus.fix_req_i = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [2:0] e;
        rst           = 1'b1;
        bus.en_i      = 1'b0;
        bus.fix_req_i = 1'b0;
        m_mode        = IDLE;
        m_pos         = 0;
        m_acq_left    = 0;
        repeat (10) step();
        exp_q.delete();
        n_vec++;
        if (bus.state_o !== IDLE || bus.cnt_o !== '0) begin
            $display("FAIL reset_state: state=%0d cnt=%0d, want state=0 cnt=0", bus.state_o, bus.cnt_o);
            n_err++;
        end
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            e = exp_q.pop_front();
            n_vec++;
            if ({bus.onepps_o, bus.threedf_o, bus.locked_o} !== 3'b000 || e !== 3'b000) begin
                $display("FAIL reset_idle_outputs: cycle %0d pins=%b model=%b, want 000",
                         k, {bus.onepps_o, bus.threedf_o, bus.locked_o}, e);
                n_err++;
            end
        end
    endtask

    task automatic test_search_blink();
        logic [2:0] e;
        logic       want_3df;
        go_idle();
        bus.en_i      = 1'b1;
        bus.fix_req_i = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            step();
            e = exp_q.pop_front();
            want_3df = (k >= 2) && (((k - 2) % P) < P / 2);
            n_vec++;
            if (bus.threedf_o !== want_3df || bus.onepps_o !== 1'b0 || bus.locked_o !== 1'b0) begin
                $display("FAIL search_blink: k=%0d pins=%b, want %b", k,
                         {bus.onepps_o, bus.threedf_o, bus.locked_o}, {1'b0, want_3df, 1'b0});
                n_err++;
            end
            n_vec++;
            if ({bus.onepps_o, bus.threedf_o, bus.locked_o} !== e) begin
                $display("FAIL search_model: k=%0d pins=%b model=%b", k,
                         {bus.onepps_o, bus.threedf_o, bus.locked_o}, e);
                n_err++;
            end
        end
    endtask

    task automatic test_fix_latency();
        logic [2:0] e;
        logic [2:0] want;
        int         first_rise;
        logic       prev_pps;
        go_idle();
        bus.en_i      = 1'b1;
        bus.fix_req_i = 1'b1;
        first_rise    = -1;
        prev_pps      = 1'b0;
        for (int k = 1; k <= 75; k++) begin
            step();
            e = exp_q.pop_front();
            if (bus.onepps_o === 1'b1 && prev_pps === 1'b0 && first_rise < 0) first_rise = k;
            prev_pps = bus.onepps_o;
            want[2] = (k >= 32) && (((k - 32) % P) < PPS_W);
            want[1] = (k >= 2) && (k < 32) && (((k - 2) % P) < P / 2);
            want[0] = (k >= 32);
            n_vec++;
            if ({bus.onepps_o, bus.threedf_o, bus.locked_o} !== want) begin
                $display("FAIL fix_waveform: k=%0d pins=%b, want %b", k,
                         {bus.onepps_o, bus.threedf_o, bus.locked_o}, want);
                n_err++;
            end
            n_vec++;
            if ({bus.onepps_o, bus.threedf_o, bus.locked_o} !== e) begin
                $display("FAIL fix_model: k=%0d pins=%b model=%b", k,
                         {bus.onepps_o, bus.threedf_o, bus.locked_o}, e);
                n_err++;
            end
        end
        n_vec++;
        if (first_rise !== 32) begin
            $display("FAIL fix_first_pps: rise at %0d cycles, want 32", first_rise);
            n_err++;
        end
    endtask

    // Continues from a held fix: drop the request mid-second.
    task automatic test_fix_drop();
        logic [2:0] e;
        int         rises;
        int         first_3df;
        logic       prev_pps;
        bit         found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            void'(exp_q.pop_front());
            if (m_mode == FIX && m_pos == 4) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            $display("FAIL fix_drop_reach: model never reached FIX pos 4, state=%0d", bus.state_o);
            n_err++;
        end
        bus.fix_req_i = 1'b0;
        rises     = 0;
        first_3df = -1;
        prev_pps  = bus.onepps_o;
        for (int k = 1; k <= 30; k++) begin
            step();
            e = exp_q.pop_front();
            if (bus.onepps_o === 1'b1 && prev_pps === 1'b0) rises++;
            prev_pps = bus.onepps_o;
            if (bus.threedf_o === 1'b1 && first_3df < 0) first_3df = k;
            n_vec++;
            if ({bus.onepps_o, bus.threedf_o, bus.locked_o} !== e) begin
                $display("FAIL fix_drop_model: k=%0d pins=%b model=%b", k,
                         {bus.onepps_o, bus.threedf_o, bus.locked_o}, e);
                n_err++;
            end
        end
        n_vec++;
        if (rises !== 0 || first_3df !== 7) begin
            $display("FAIL fix_drop_timing: pps rises=%0d 3df first at %0d, want 0 and 7", rises, first_3df);
            n_err++;
        end
    endtask

    task automatic test_acquire_abort();
        logic [2:0] e;
        int         acq_cycles;
        bit         found;
        bit         locked;
        go_idle();
        bus.en_i      = 1'b1;
        bus.fix_req_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            void'(exp_q.pop_front());
            if (m_mode == ACQUIRE && m_pos == 3) found = 1'b1;
        end
        bus.fix_req_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            e = exp_q.pop_front();
            n_vec++;
            if ({bus.onepps_o, bus.threedf_o, bus.locked_o} !== e) begin
                $display("FAIL abort_model: k=%0d pins=%b model=%b", k,
                         {bus.onepps_o, bus.threedf_o, bus.locked_o}, e);
                n_err++;
            end
        end
        n_vec++;
        if (bus.state_o !== SEARCH || !found) begin
            $display("FAIL abort_to_search: state=%0d reached=%0d, want state=%0d", bus.state_o, found, SEARCH);
            n_err++;
        end
        bus.fix_req_i = 1'b1;
        acq_cycles = 0;
        locked     = 1'b0;
        for (int k = 0; k < 60 && !locked; k++) begin
            step();
            e = exp_q.pop_front();
            if (bus.state_o === ACQUIRE) acq_cycles++;
            if (bus.state_o === FIX) locked = 1'b1;
            n_vec++;
            if ({bus.onepps_o, bus.threedf_o, bus.locked_o} !== e) begin
                $display("FAIL reacquire_model: k=%0d pins=%b model=%b", k,
                         {bus.onepps_o, bus.threedf_o, bus.locked_o}, e);
                n_err++;
            end
        end
        n_vec++;
        if (acq_cycles !== ACQ_N * P || !locked) begin
            $display("FAIL reacquire_length: %0d ACQUIRE cycles locked=%0d, want %0d and 1",
                     acq_cycles, locked, ACQ_N * P);
            n_err++;
        end
    endtask

    // Cut a live pulse, once with reset and once with disable.
    task automatic test_cut_pulse();
        bit found;
        for (int pass = 0; pass < 2; pass++) begin
            go_idle();
            bus.en_i      = 1'b1;
            bus.fix_req_i = 1'b1;
            found = 1'b0;
            for (int k = 0; k < 60 && !found; k++) begin
                step();
                void'(exp_q.pop_front());
                if (bus.onepps_o === 1'b1) found = 1'b1;
            end
            if (pass == 0) rst = 1'b1;
            else bus.en_i = 1'b0;
            step();
            void'(exp_q.pop_front());
            n_vec++;
            if (!found || {bus.onepps_o, bus.threedf_o, bus.locked_o} !== 3'b000 ||
                bus.cnt_o !== '0 || bus.state_o !== IDLE) begin
                $display("FAIL cut_pulse_%0d: seen=%0d pins=%b cnt=%0d state=%0d, want 1 000 0 0",
                         pass, found, {bus.onepps_o, bus.threedf_o, bus.locked_o}, bus.cnt_o, bus.state_o);
                n_err++;
            end
            rst = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [2:0] e;
        go_idle();
        bus.en_i      = 1'b1;
        bus.fix_req_i = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 39) == 0) bus.fix_req_i = ~bus.fix_req_i;
            if (bus.en_i && $urandom_range(0, 149) == 0) bus.en_i = 1'b0;
            else if (!bus.en_i && $urandom_range(0, 3) == 0) bus.en_i = 1'b1;
            rst = ($urandom_range(0, 299) == 0);
            step();
            e = exp_q.pop_front();
            n_vec++;
            if ({bus.onepps_o, bus.threedf_o, bus.locked_o} !== e ||
                bus.state_o !== m_mode || bus.cnt_o !== CW'(m_pos)) begin
                $display("FAIL random: k=%0d pins=%b state=%0d cnt=%0d, want pins=%b state=%0d cnt=%0d",
                         k, {bus.onepps_o, bus.threedf_o, bus.locked_o}, bus.state_o, bus.cnt_o,
                         e, m_mode, m_pos);
                n_err++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.en_i      = 1'b0;
        bus.fix_req_i = 1'b0;
        test_reset();
        test_search_blink();
        test_fix_latency();
        test_fix_drop();
        test_acquire_abort();
        test_cut_pulse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
